// File: rtl/posit_decoder_pipe_if.sv
// Operand/result bundle for the posit decoder: operand handshake in, decoded
// fields and output-valid back out.
interface posit_decoder_pipe_if #(
  parameter int posit_width = 8,
  parameter int es          = 1
);
  localparam int scale_width = es + $clog2(posit_width) + 1;

  logic                          en;
  logic                          stall;
  logic [posit_width-1:0]        posit_in;
  logic                          in_ready;
  logic                          sign;
  logic [posit_width-1:0]        frac;
  logic signed [scale_width-1:0] sf;
  logic                          exception;
  logic                          zero;
  logic                          ready;

  modport master (
    output en, stall, posit_in,
    input  in_ready, sign, frac, sf, exception, zero, ready
  );

  modport slave (
    input  en, stall, posit_in,
    output in_ready, sign, frac, sf, exception, zero, ready
  );
endinterface

// File: rtl/posit_decoder_pipe.sv
// Two-stage posit decoder: stage 1 classifies and takes the magnitude, stage 2
// extracts regime/exponent/fraction into the encoder's sign/frac/sf format.
module posit_decoder_pipe #(
  parameter int posit_width = 8,
  parameter int es          = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  posit_decoder_pipe_if.slave  bus
);
  localparam int N           = posit_width;
  localparam int scale_width = es + $clog2(posit_width) + 1;
  localparam int run_width   = $clog2(posit_width) + 1;
  localparam int ext_width   = (N - 1) + es + (N - 1);
  localparam logic signed [scale_width-1:0] one_s = 1;

  logic           v1_q, v1_d;
  logic           s1_q, s1_d;
  logic           nar1_q, nar1_d;
  logic           zero1_q, zero1_d;
  logic [N-2:0]   abs1_q, abs1_d;

  logic                          ready_q, ready_d;
  logic                          sign_q, sign_d;
  logic [N-1:0]                  frac_q, frac_d;
  logic signed [scale_width-1:0] sf_q, sf_d;
  logic                          exc_q, exc_d;
  logic                          zero_q, zero_d;

  logic                          r0;
  logic                          run_open;
  logic [run_width-1:0]          run_len;
  logic [ext_width-1:0]          ext;
  logic [es-1:0]                 e_bits;
  logic [N-2:0]                  frac_bits;
  logic signed [scale_width-1:0] m_s;
  logic signed [scale_width-1:0] k;
  logic signed [scale_width-1:0] sf_calc;

  assign bus.in_ready = ~bus.stall;

  // NOTE: every variable gets a hold/default value first so no latch is inferred.
  always_comb begin : stage1_next
    v1_d    = v1_q;
    s1_d    = s1_q;
    nar1_d  = nar1_q;
    zero1_d = zero1_q;
    abs1_d  = abs1_q;
    if (!bus.stall) begin
      v1_d = bus.en;
      if (bus.en) begin
        s1_d    = bus.posit_in[N-1];
        nar1_d  = (bus.posit_in == {1'b1, {(N-1){1'b0}}});
        zero1_d = (bus.posit_in == '0);
        // Low N-1 bits of the negation depend only on the low N-1 input bits.
        abs1_d  = bus.posit_in[N-1] ? (~bus.posit_in[N-2:0] + {{(N-2){1'b0}}, 1'b1})
                                    : bus.posit_in[N-2:0];
      end
    end
  end

  always_comb begin : regime_decode
    r0       = abs1_q[N-2];
    run_len  = '0;
    run_open = 1'b1;
    for (int i = N - 2; i >= 0; i--) begin
      if (run_open && (abs1_q[i] == r0)) run_len = run_len + 1'b1;
      else                               run_open = 1'b0;
    end
    // Shift past the run and its terminator; a missing terminator shifts in zeros.
    ext       = {abs1_q, {(es + N - 1){1'b0}}} << (run_len + 1'b1);
    e_bits    = ext[ext_width-1 -: es];
    frac_bits = ext[ext_width-1-es -: N-1];
    m_s       = signed'({{(scale_width - run_width){1'b0}}, run_len});
    k         = r0 ? (m_s - one_s) : -m_s;
    sf_calc   = (k <<< es) + signed'({{(scale_width - es){1'b0}}, e_bits});
  end

  always_comb begin : stage2_next
    ready_d = ready_q;
    sign_d  = sign_q;
    frac_d  = frac_q;
    sf_d    = sf_q;
    exc_d   = exc_q;
    zero_d  = zero_q;
    if (!bus.stall) begin
      ready_d = v1_q;
      if (v1_q) begin
        exc_d  = nar1_q;
        zero_d = zero1_q;
        if (nar1_q || zero1_q) begin
          sign_d = nar1_q;
          frac_d = '0;
          sf_d   = '0;
        end else begin
          sign_d = s1_q;
          frac_d = {1'b1, frac_bits};
          sf_d   = sf_calc;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q    <= 1'b0;
      s1_q    <= 1'b0;
      nar1_q  <= 1'b0;
      zero1_q <= 1'b0;
      abs1_q  <= '0;
      ready_q <= 1'b0;
      sign_q  <= 1'b0;
      frac_q  <= '0;
      sf_q    <= '0;
      exc_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      v1_q    <= v1_d;
      s1_q    <= s1_d;
      nar1_q  <= nar1_d;
      zero1_q <= zero1_d;
      abs1_q  <= abs1_d;
      ready_q <= ready_d;
      sign_q  <= sign_d;
      frac_q  <= frac_d;
      sf_q    <= sf_d;
      exc_q   <= exc_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.ready     = ready_q;
  assign bus.sign      = sign_q;
  assign bus.frac      = frac_q;
  assign bus.sf        = sf_q;
  assign bus.exception = exc_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_posit_decoder_pipe.sv
// Bench for posit_decoder_pipe: bit-string reference decoder plus a posit
// encoder for round-trip checks, compared against the DUT on every cycle.
module tb_posit_decoder_pipe;
  localparam int N  = 8;
  localparam int ES = 1;

  typedef struct {
    logic sign;
    int   frac;
    int   sf;
    logic exc;
    logic zero;
  } dec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  posit_decoder_pipe_if #(.posit_width(N), .es(ES)) bus ();

  posit_decoder_pipe #(.posit_width(N), .es(ES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference decode straight from the bit-string reading of a posit.
  function automatic dec_t decode(input int p);
    dec_t r;
    int mag, body, nb, r0, m, k, rem, tail, e, fb, fbits;
    r.sign = 1'b0; r.frac = 0; r.sf = 0; r.exc = 1'b0; r.zero = 1'b0;
    if (p == (1 << (N - 1))) begin
      r.sign = 1'b1;
      r.exc  = 1'b1;
      return r;
    end
    if (p == 0) begin
      r.zero = 1'b1;
      return r;
    end
    r.sign = ((p >> (N - 1)) & 1) != 0;
    mag  = r.sign ? ((1 << N) - p) : p;
    nb   = N - 1;
    body = mag & ((1 << nb) - 1);
    r0   = (body >> (nb - 1)) & 1;
    m    = 0;
    while (m < nb && ((body >> (nb - 1 - m)) & 1) == r0) m++;
    k    = (r0 != 0) ? m - 1 : -m;
    rem  = nb - m - 1;
    if (rem < 0) rem = 0;
    tail = body & ((1 << rem) - 1);
    if (rem >= ES) begin
      e  = tail >> (rem - ES);
      fb = rem - ES;
    end else begin
      e  = tail << (ES - rem);
      fb = 0;
    end
    fbits  = tail & ((1 << fb) - 1);
    r.frac = (1 << (N - 1)) | (fbits << (N - 1 - fb));
    r.sf   = k * (1 << ES) + e;
    return r;
  endfunction

  // Downstream encoder stand-in: rebuilds the posit code from decoded fields.
  function automatic int encode(input logic s, input int f, input int sf,
                                input logic nar, input logic z);
    longint acc;
    int len, k, e, mag;
    if (nar) return 1 << (N - 1);
    if (z)   return 0;
    k   = sf >>> ES;
    e   = sf - k * (1 << ES);
    acc = 0;
    len = 0;
    if (k >= 0) begin
      for (int i = 0; i <= k; i++) begin acc = (acc << 1) | 1; len++; end
      acc = acc << 1; len++;
    end else begin
      for (int i = 0; i < -k; i++) begin acc = acc << 1; len++; end
      acc = (acc << 1) | 1; len++;
    end
    for (int i = ES - 1; i >= 0; i--) begin acc = (acc << 1) | ((e >> i) & 1); len++; end
    for (int i = N - 2; i >= 0; i--) begin acc = (acc << 1) | ((f >> i) & 1); len++; end
    mag = int'(acc >> (len - (N - 1))) & ((1 << (N - 1)) - 1);
    return s ? (((1 << N) - mag) & ((1 << N) - 1)) : mag;
  endfunction

  // Cycle-level expectation: the output shows whatever was offered two unstalled edges ago.
  logic         pend_v = 1'b0;
  logic [N-1:0] pend_p = '0;
  logic         out_v  = 1'b0;
  logic [N-1:0] out_p  = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_v = 1'b0;
      out_v  = 1'b0;
    end else if (!bus.stall) begin
      if (pend_v) out_p = pend_p;
      out_v  = pend_v;
      pend_v = bus.en;
      if (bus.en) pend_p = bus.posit_in;
    end
  end

  always begin
    dec_t rd;
    @(negedge clk);
    #1;
    check("in_ready", bus.in_ready, !bus.stall);
    check("ready", bus.ready, out_v);
    if (out_v) begin
      rd = decode(int'(out_p));
      check("sign", bus.sign, rd.sign);
      check("frac", bus.frac, rd.frac);
      check("sf", $signed(bus.sf), rd.sf);
      check("exception", bus.exception, rd.exc);
      check("zero", bus.zero, rd.zero);
      check("roundtrip", encode(bus.sign, int'(bus.frac), int'($signed(bus.sf)),
                                bus.exception, bus.zero), int'(out_p));
    end
  end

  // NOTE: bench inputs are driven with blocking assignments just after the falling edge.
  task automatic step(input logic e, input int p, input logic s);
    bus.en       = e;
    bus.posit_in = p[N-1:0];
    bus.stall    = s;
    @(negedge clk);
  endtask

  task automatic check_lit(input string name, input logic s, input int f, input int sf,
                           input logic ex, input logic z);
    check({name, "_ready"}, bus.ready, 1);
    check({name, "_sign"}, bus.sign, s);
    check({name, "_frac"}, bus.frac, f);
    check({name, "_sf"}, $signed(bus.sf), sf);
    check({name, "_exc"}, bus.exception, ex);
    check({name, "_zero"}, bus.zero, z);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ready"}, bus.ready, 0);
    check({name, "_sign"}, bus.sign, 0);
    check({name, "_frac"}, bus.frac, 0);
    check({name, "_sf"}, $signed(bus.sf), 0);
    check({name, "_exc"}, bus.exception, 0);
    check({name, "_zero"}, bus.zero, 0);
  endtask

  initial begin
    dec_t pin;
    int code;
    bus.en       = 1'b0;
    bus.stall    = 1'b0;
    bus.posit_in = '0;
    reset        = 1'b1;
    @(negedge clk);
    check_all_zero("reset_state");
    reset = 1'b0;

    pin = decode(32'h5A);
    check("model_5A_sf", pin.sf, 1);
    check("model_5A_frac", pin.frac, 32'hD0);
    pin = decode(32'h01);
    check("model_01_sf", pin.sf, -12);
    check("model_7F_sf", decode(32'h7F).sf, 12);

    step(1, 32'h40, 0); step(0, 0, 0); check_lit("p40", 0, 32'h80, 0, 0, 0);
    step(1, 32'h5A, 0); step(0, 0, 0); check_lit("p5A", 0, 32'hD0, 1, 0, 0);
    step(1, 32'hC0, 0); step(0, 0, 0); check_lit("pC0", 1, 32'h80, 0, 0, 0);
    step(1, 32'h7F, 0); step(0, 0, 0); check_lit("p7F", 0, 32'h80, 12, 0, 0);
    step(1, 32'h01, 0); step(0, 0, 0); check_lit("p01", 0, 32'h80, -12, 0, 0);
    step(1, 32'h80, 0); step(0, 0, 0); check_lit("p80", 1, 0, 0, 1, 0);
    step(1, 32'h00, 0); step(0, 0, 0); check_lit("p00", 0, 0, 0, 0, 1);
    step(0, 0, 0);
    check("bubble_ready", bus.ready, 0);

    // Back-to-back with a two-cycle stall after the second operand.
    step(1, 32'h40, 0);
    step(1, 32'h5A, 0);
    check_lit("stall_pre", 0, 32'h80, 0, 0, 0);
    step(1, 32'h7F, 1);
    check_lit("stall_hold1", 0, 32'h80, 0, 0, 0);
    step(1, 32'h7F, 1);
    check_lit("stall_hold2", 0, 32'h80, 0, 0, 0);
    step(1, 32'h7F, 0);
    check_lit("stall_5A", 0, 32'hD0, 1, 0, 0);
    step(0, 0, 0);
    check_lit("stall_7F", 0, 32'h80, 12, 0, 0);
    step(0, 0, 0);
    check("stall_drain", bus.ready, 0);

    // Reset while two operands are in flight.
    step(1, 32'h40, 0);
    step(1, 32'h5A, 0);
    #2 reset = 1'b1;
    #1 check_all_zero("reset_async");
    @(negedge clk);
    reset = 1'b0;
    step(0, 0, 0);
    step(0, 0, 0);
    check("reset_no_pulse", bus.ready, 0);

    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 7))
        0:       code = 32'h80;
        1:       code = 32'h00;
        2:       code = ($urandom_range(0, 1) != 0) ? 32'h7F : 32'h81;
        default: code = int'($urandom_range(0, 255));
      endcase
      step($urandom_range(0, 3) != 0, code, $urandom_range(0, 3) == 0);
    end

    for (int c = 0; c < 256; c++) step(1, c, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
